mem_bus_if: RTL and testbench
=============================

// Module: mem_bus_if
// PURPOSE
//  Memory bus interface between the 8-bit multicycle datapath and external memory.
//  Consumes the datapath's mar/writedata and read/write requests, then drives a
//  handshaked memory port that tolerates wait states.
//  Returns registered read data as memdata.
//  Stalls the controller until the access completes or times out.
// PARAMETERS
//  WIDTH     8   data and address width
//  WAIT_MAX  15  max ACCESS cycles without mem_ready before timeout (1..255)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  req_rd     in   1      CPU read request, held high while stall=1
//  req_wr     in   1      CPU write request, held high while stall=1
//  mar        in   WIDTH  access address from datapath
//  writedata  in   WIDTH  write data from datapath
//  memdata    out  WIDTH  registered read data to datapath MDR mux
//  stall      out  1      controller must hold state and inputs while high
//  bus_err    out  1      one-cycle pulse: timeout or illegal request
//  mem_adr    out  WIDTH  latched address to memory
//  mem_wdata  out  WIDTH  latched write data to memory
//  mem_re     out  1      memory read strobe
//  mem_we     out  1      memory write strobe
//  mem_rdata  in   WIDTH  memory read data, sampled when mem_ready=1
//  mem_ready  in   1      memory completes current access this cycle
// BEHAVIOUR
//  Clocking and reset
//   - One clock. Reset is synchronous, active-high.
//   - Reset forces: state=IDLE, memdata=0, mem_adr=0, mem_wdata=0, mem_re=0,
//     mem_we=0, bus_err=0, wait counter=0.
//   - Reset mid-access drops strobes on the next edge. The access is abandoned
//     with no bus_err.
//  FSM states: IDLE, ACCESS, DONE, ERR
//  IDLE
//   - req_rd^req_wr: latch mar into mem_adr and writedata into mem_wdata,
//     record direction, go to ACCESS.
//   - stall = req_rd|req_wr (combinational, same cycle).
//   - req_rd&req_wr: illegal. Go to ERR; no memory strobe is ever raised.
//  ACCESS
//   - Raise mem_re or mem_we (registered, constant throughout ACCESS). stall=1.
//   - mem_ready=1: read captures mem_rdata into memdata. Go to DONE.
//   - Wait counter increments each ACCESS cycle without mem_ready.
//   - Counter reaching WAIT_MAX with mem_ready=0: go to ERR.
//   - mem_ready on the same cycle the counter hits WAIT_MAX: completion wins.
//  DONE
//   - Strobes low, stall=0, counter cleared. Go to IDLE unconditionally.
//   - Requests seen in DONE are ignored. The CPU re-issues them in IDLE.
//  ERR
//   - bus_err=1, stall=0, strobes low.
//   - Read: memdata=all ones (8'hFF). Write: memdata unchanged.
//   - Go to IDLE.
//  Timing and data rules
//   - Latency: request at cycle 0, zero-wait memory responds in cycle 1,
//     stall low and memdata valid in cycle 2. Each wait state adds one cycle.
//   - memdata holds its value until the next completed read, timeout read, or
//     reset. Writes never alter memdata.
//   - mem_adr and mem_wdata are stable from entry to ACCESS until the next
//     accepted request. Changes to mar/writedata during ACCESS are ignored.
// TESTING
//  1. Zero-wait read: mem[0x68]=0x3C, req_rd with mar=0x68, mem_ready=1 every
//     cycle -> stall high cycles 0-1, memdata=0x3C at cycle 2, mem_re for 1 cycle.
//  2. Write with 3 wait states: mar=0x10, writedata=0xA5 -> mem_we high 4 cycles
//     with mem_adr=0x10, mem_wdata=0xA5. memdata unchanged, stall low in cycle 5.
//  3. Timeout read: mem_ready stuck 0 -> after 15 ACCESS cycles, bus_err pulses
//     1 cycle, memdata=0xFF, stall low, FSM returns to IDLE.
//  4. Illegal request: req_rd=req_wr=1 -> bus_err pulse next cycle. mem_re and
//     mem_we never asserted.
//  5. Reset mid-access: assert reset in 2nd wait cycle of a read -> next cycle
//     strobes=0, memdata=0, stall=0. A following read of 0x55 completes normally.
//  6. Back-to-back: read 0x01 then immediate write 0x02 -> no request lost,
//     2nd access starts in IDLE cycle after DONE, mar change during ACCESS ignored.

Source files
------------

// File: rtl/mem_bus_if_if.sv
// Memory-side port of the datapath bus interface: latched address/data,
// read/write strobes, and the wait-state handshake returned by memory.
interface mem_bus_if_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_re;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_adr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_adr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_bus_if.sv
// Bridges datapath read/write requests onto a wait-state tolerant memory port.
// Latency: request cycle 0, zero-wait memory answers cycle 1, data/stall release cycle 2.
// Backpressure: stall holds the controller until completion, timeout or illegal request.
module mem_bus_if #(
    parameter int WIDTH    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [WIDTH-1:0] mar,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             stall,
    output logic             bus_err,
    mem_bus_if_if.master     mem
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       is_rd;

    always_comb begin
        stall = 1'b0;
        if (state == ACCESS)
            stall = 1'b1;
        else if (state == IDLE)
            stall = req_rd | req_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            is_rd         <= 1'b0;
            memdata       <= '0;
            bus_err       <= 1'b0;
            mem.mem_adr   <= '0;
            mem.mem_wdata <= '0;
            mem.mem_re    <= 1'b0;
            mem.mem_we    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (req_rd ^ req_wr) begin
                        mem.mem_adr   <= mar;
                        mem.mem_wdata <= writedata;
                        mem.mem_re    <= req_rd;
                        mem.mem_we    <= req_wr;
                        is_rd         <= req_rd;
                        state         <= ACCESS;
                    end else if (req_rd & req_wr) begin
                        // Illegal request: flag it without ever touching memory.
                        is_rd   <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= ERR;
                    end
                end
                ACCESS: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (mem.mem_ready) begin
                        if (is_rd)
                            memdata <= mem.mem_rdata;
                        mem.mem_re <= 1'b0;
                        mem.mem_we <= 1'b0;
                        wait_cnt   <= 8'd0;
                        state      <= DONE;
                    end else if (wait_cnt == 8'(WAIT_MAX - 1)) begin
                        if (is_rd)
                            memdata <= '1;
                        mem.mem_re <= 1'b0;
                        mem.mem_we <= 1'b0;
                        bus_err    <= 1'b1;
                        wait_cnt   <= 8'd0;
                        state      <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end
                default: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: per-cycle vector table plus timeout and
// completion-at-limit sequences.
module tb_mem_bus_if;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_rd;
    logic       req_wr;
    logic [7:0] mar;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic       stall;
    logic       bus_err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_bus_if_if #(.WIDTH(8)) mbus ();

    mem_bus_if #(.WIDTH(8), .WAIT_MAX(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .mar       (mar),
        .writedata (writedata),
        .memdata   (memdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .mem       (mbus.master)
    );

    typedef struct {
        logic       rst;
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rdat;
        logic       rdy;
        logic       e_stall;
        logic       e_err;
        logic       e_re;
        logic       e_we;
        logic [7:0] e_md;
        logic [7:0] e_adr;
        logic [7:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, rd, wr, input logic [7:0] a, d, rdat,
                                input logic rdy, st, er, re, we,
                                input logic [7:0] md, adr, wd);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.rdat = rdat; v.rdy = rdy;
        v.e_stall = st; v.e_err = er; v.e_re = re; v.e_we = we;
        v.e_md = md; v.e_adr = adr; v.e_wd = wd;
        return v;
    endfunction

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rst, rd, wr, input logic [7:0] a, d, rdat, input logic rdy);
        @(negedge clk);
        reset           = rst;
        req_rd          = rd;
        req_wr          = wr;
        mar             = a;
        writedata       = d;
        mbus.mem_rdata  = rdat;
        mbus.mem_ready  = rdy;
        #1;
    endtask

    task automatic expect_out(input string nm, input logic st, er, re, we,
                              input logic [7:0] md, adr, wd);
        logic [27:0] act;
        logic [27:0] exp;
        act = {stall, bus_err, mbus.mem_re, mbus.mem_we, memdata, mbus.mem_adr, mbus.mem_wdata};
        exp = {st, er, re, we, md, adr, wd};
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got stall=%b err=%b re=%b we=%b memdata=%h adr=%h wdata=%h, expected stall=%b err=%b re=%b we=%b memdata=%h adr=%h wdata=%h",
                     nm, act[27], act[26], act[25], act[24], act[23:16], act[15:8], act[7:0],
                     st, er, re, we, md, adr, wd);
    endtask

    initial begin
        reset          = 1'b1;
        req_rd         = 1'b0;
        req_wr         = 1'b0;
        mar            = 8'h00;
        writedata      = 8'h00;
        mbus.mem_rdata = 8'h00;
        mbus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        //              rst rd wr mar    wd     rdata  rdy  stall err re we memdata adr   wdata
        // reset state
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 0,   0,   0,  0, 0, 8'h00, 8'h00, 8'h00));
        // zero-wait read of 0x68 -> 0x3C
        vecs.push_back(mk(0, 1, 0, 8'h68, 8'h00, 8'h3C, 1,   1,   0,  0, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h68, 8'h00, 8'h3C, 1,   1,   0,  1, 0, 8'h00, 8'h68, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h68, 8'h00, 8'h00, 1,   0,   0,  0, 0, 8'h3C, 8'h68, 8'h00));
        // write 0xA5 to 0x10 with 3 wait states
        vecs.push_back(mk(0, 0, 1, 8'h10, 8'hA5, 8'h00, 0,   1,   0,  0, 0, 8'h3C, 8'h68, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h10, 8'hA5, 8'h00, 0,   1,   0,  0, 1, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 0, 1, 8'h10, 8'hA5, 8'h00, 0,   1,   0,  0, 1, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 0, 1, 8'h10, 8'hA5, 8'h00, 0,   1,   0,  0, 1, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 0, 1, 8'h10, 8'hA5, 8'h77, 1,   1,   0,  0, 1, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 0, 0, 8'h10, 8'hA5, 8'h00, 0,   0,   0,  0, 0, 8'h3C, 8'h10, 8'hA5));
        // illegal request: both strobes requested
        vecs.push_back(mk(0, 1, 1, 8'h20, 8'h99, 8'h00, 1,   1,   0,  0, 0, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 0, 0, 8'h20, 8'h99, 8'h00, 1,   0,   1,  0, 0, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 0, 0, 8'h20, 8'h99, 8'h00, 1,   0,   0,  0, 0, 8'h3C, 8'h10, 8'hA5));
        // reset during the 2nd wait cycle of a read, then a normal read of 0x55
        vecs.push_back(mk(0, 1, 0, 8'h33, 8'h00, 8'h00, 0,   1,   0,  0, 0, 8'h3C, 8'h10, 8'hA5));
        vecs.push_back(mk(0, 1, 0, 8'h33, 8'h00, 8'h00, 0,   1,   0,  1, 0, 8'h3C, 8'h33, 8'h00));
        vecs.push_back(mk(1, 1, 0, 8'h33, 8'h00, 8'h00, 0,   1,   0,  1, 0, 8'h3C, 8'h33, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h33, 8'h00, 8'h00, 0,   0,   0,  0, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h55, 8'h00, 8'h55, 1,   1,   0,  0, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h55, 8'h00, 8'h55, 1,   1,   0,  1, 0, 8'h00, 8'h55, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h55, 8'h00, 8'h00, 1,   0,   0,  0, 0, 8'h55, 8'h55, 8'h00));
        // back-to-back read 0x01 then write 0x02; mar changes mid-access are ignored
        vecs.push_back(mk(0, 1, 0, 8'h01, 8'h00, 8'hC3, 1,   1,   0,  0, 0, 8'h55, 8'h55, 8'h00));
        vecs.push_back(mk(0, 1, 0, 8'h7E, 8'h00, 8'hC3, 1,   1,   0,  1, 0, 8'h55, 8'h01, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h02, 8'h02, 8'h00, 1,   0,   0,  0, 0, 8'hC3, 8'h01, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h02, 8'h02, 8'h00, 1,   1,   0,  0, 0, 8'hC3, 8'h01, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h7F, 8'h6B, 8'h00, 1,   1,   0,  0, 1, 8'hC3, 8'h02, 8'h02));
        vecs.push_back(mk(0, 0, 0, 8'h7F, 8'h6B, 8'h00, 1,   0,   0,  0, 0, 8'hC3, 8'h02, 8'h02));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rdat, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_err, vecs[i].e_re,
                       vecs[i].e_we, vecs[i].e_md, vecs[i].e_adr, vecs[i].e_wd);
        end

        // Timeout read: 15 ACCESS cycles with mem_ready stuck low
        drive(0, 1, 0, 8'h44, 8'h00, 8'h00, 0);
        expect_out("to_req", 1, 0, 0, 0, 8'hC3, 8'h02, 8'h02);
        for (int k = 1; k <= 15; k++) begin
            drive(0, 1, 0, 8'h44, 8'h00, 8'h00, 0);
            expect_out($sformatf("to_access%0d", k), 1, 0, 1, 0, 8'hC3, 8'h44, 8'h00);
        end
        drive(0, 0, 0, 8'h44, 8'h00, 8'h00, 0);
        expect_out("to_err", 0, 1, 0, 0, 8'hFF, 8'h44, 8'h00);
        drive(0, 0, 0, 8'h44, 8'h00, 8'h00, 0);
        expect_out("to_idle", 0, 0, 0, 0, 8'hFF, 8'h44, 8'h00);

        // mem_ready arrives on the last allowed wait cycle: completion wins
        drive(0, 1, 0, 8'h46, 8'h00, 8'h00, 0);
        expect_out("lim_req", 1, 0, 0, 0, 8'hFF, 8'h44, 8'h00);
        for (int k = 1; k <= 14; k++) begin
            drive(0, 1, 0, 8'h46, 8'h00, 8'h00, 0);
            expect_out($sformatf("lim_wait%0d", k), 1, 0, 1, 0, 8'hFF, 8'h46, 8'h00);
        end
        drive(0, 1, 0, 8'h46, 8'h00, 8'h5A, 1);
        expect_out("lim_ready", 1, 0, 1, 0, 8'hFF, 8'h46, 8'h00);
        drive(0, 0, 0, 8'h46, 8'h00, 8'h00, 0);
        expect_out("lim_done", 0, 0, 0, 0, 8'h5A, 8'h46, 8'h00);
        drive(0, 0, 0, 8'h46, 8'h00, 8'h00, 0);
        expect_out("lim_idle", 0, 0, 0, 0, 8'h5A, 8'h46, 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
